// File: rtl/hazard_tracker_pkg.sv
// Shared definitions for the pipeline hazard tracker.
//   REG_W   : register-number width
//   TNEW_W  : width of tnew / tuse latency fields
//   FWD_*   : forwarding-select codes on the fwd_* outputs
//   fwd_hit : one producer can supply a given operand this cycle
//   fwd_pick: priority-encode E over M over W
package hazard_tracker_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 5;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  // A producer is a forwarding source only once its result exists (tnew==0);
  // register 0 is hard-wired and never forwarded.
  function automatic logic fwd_hit(input logic              we,
                                   input logic [REG_W-1:0]  wa,
                                   input logic [TNEW_W-1:0] tnew,
                                   input logic [REG_W-1:0]  ra);
    return we && (wa == ra) && (ra != '0) && (tnew == '0);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic hit_e,
                                          input logic hit_m,
                                          input logic hit_w);
    if (hit_e) return FWD_E;
    if (hit_m) return FWD_M;
    if (hit_w) return FWD_W;
    return FWD_GRF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage tracking register.
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-high clear
//   i_bubble : load all-zero instead of i_d
//   i_d      : fields entering the stage; tnew occupies the TnewW LSBs
//   o_q      : registered fields
// With DecTnew set, the tnew field is decremented (floor 0) on entry, which
// models one cycle of progress as the producer advances a stage.
module hazard_stage_reg #(
  parameter int unsigned Width   = 6,
  parameter int unsigned TnewW   = 5,
  parameter bit          DecTnew = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_bubble,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_q;
  logic [Width-1:0] w_d;

  always_comb begin
    w_d = i_d;
    if (DecTnew && (i_d[TnewW-1:0] != '0)) begin
      w_d[TnewW-1:0] = i_d[TnewW-1:0] - 1'b1;
    end
    if (i_bubble) begin
      w_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_tracker.sv
// Stall and forwarding control for a 5-stage MIPS-style pipeline.
// Tracks producers in E, M and W and compares them with the D-stage operands.
//   clk, reset              : clock and synchronous active-high reset
//   d_ra1/d_ra2, d_re1/d_re2: D-stage source registers and read enables
//   d_tuse_rs/d_tuse_rt     : cycles from D until each operand is consumed
//   d_we/d_wa/d_tnew        : D-stage destination and result latency from E
//   stall                   : hold PC and IF/ID, bubble into E
//   fwd_rs_d/fwd_rt_d       : D-operand forwarding source (E/M/W)
//   fwd_rs_e/fwd_rt_e       : E-operand forwarding source (M/W)
//   fwd_rt_m                : M store-data forwarding source (W)
//   stall_cnt               : saturating count of stalled cycles
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_W-1:0]       d_ra1,
  input  logic [REG_W-1:0]       d_ra2,
  input  logic                   d_re1,
  input  logic                   d_re2,
  input  logic [TNEW_W-1:0]      d_tuse_rs,
  input  logic [TNEW_W-1:0]      d_tuse_rt,
  input  logic                   d_we,
  input  logic [REG_W-1:0]       d_wa,
  input  logic [TNEW_W-1:0]      d_tnew,
  output logic                   stall,
  output logic [1:0]             fwd_rs_d,
  output logic [1:0]             fwd_rt_d,
  output logic [1:0]             fwd_rs_e,
  output logic [1:0]             fwd_rt_e,
  output logic [1:0]             fwd_rt_m,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned EW = 3 * REG_W + 1 + TNEW_W;  // ra1, ra2, we, wa, tnew
  localparam int unsigned MW = 2 * REG_W + 1 + TNEW_W;  // ra2, we, wa, tnew
  localparam int unsigned WW = REG_W + 1;               // we, wa

  logic              w_stall;
  logic              w_d_we;
  logic [EW-1:0]     w_e_d;
  logic [EW-1:0]     w_e_q;
  logic [MW-1:0]     w_m_d;
  logic [MW-1:0]     w_m_q;
  logic [WW-1:0]     w_w_d;
  logic [WW-1:0]     w_w_q;

  logic [REG_W-1:0]  w_e_ra1;
  logic [REG_W-1:0]  w_e_ra2;
  logic              w_e_we;
  logic [REG_W-1:0]  w_e_wa;
  logic [TNEW_W-1:0] w_e_tnew;
  logic [REG_W-1:0]  w_m_ra2;
  logic              w_m_we;
  logic [REG_W-1:0]  w_m_wa;
  logic [TNEW_W-1:0] w_m_tnew;
  logic              w_w_we;
  logic [REG_W-1:0]  w_w_wa;

  logic              w_rs_stall;
  logic              w_rt_stall;

  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // A write to $0 is architecturally dropped, so it never becomes a producer.
  assign w_d_we = d_we && (d_wa != '0);

  assign w_e_d = {d_ra1, d_ra2, w_d_we, d_wa, d_tnew};
  assign {w_e_ra1, w_e_ra2, w_e_we, w_e_wa, w_e_tnew} = w_e_q;

  assign w_m_d = {w_e_ra2, w_e_we, w_e_wa, w_e_tnew};
  assign {w_m_ra2, w_m_we, w_m_wa, w_m_tnew} = w_m_q;

  assign w_w_d = {w_m_we, w_m_wa};
  assign {w_w_we, w_w_wa} = w_w_q;

  hazard_stage_reg #(
    .Width   (EW),
    .TnewW   (TNEW_W),
    .DecTnew (1'b0)
  ) u_stage_e (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_bubble (w_stall),
    .i_d      (w_e_d),
    .o_q      (w_e_q)
  );

  hazard_stage_reg #(
    .Width   (MW),
    .TnewW   (TNEW_W),
    .DecTnew (1'b1)
  ) u_stage_m (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_bubble (1'b0),
    .i_d      (w_m_d),
    .o_q      (w_m_q)
  );

  // W carries no tnew field; its result is always available.
  hazard_stage_reg #(
    .Width   (WW),
    .TnewW   (TNEW_W),
    .DecTnew (1'b0)
  ) u_stage_w (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_bubble (1'b0),
    .i_d      (w_w_d),
    .o_q      (w_w_q)
  );

  // Stall when a matching producer's result arrives later than the consumer needs it.
  assign w_rs_stall = d_re1 && (d_ra1 != '0) &&
                      ((w_e_we && (w_e_wa == d_ra1) && (w_e_tnew > d_tuse_rs)) ||
                       (w_m_we && (w_m_wa == d_ra1) && (w_m_tnew > d_tuse_rs)));
  assign w_rt_stall = d_re2 && (d_ra2 != '0) &&
                      ((w_e_we && (w_e_wa == d_ra2) && (w_e_tnew > d_tuse_rt)) ||
                       (w_m_we && (w_m_wa == d_ra2) && (w_m_tnew > d_tuse_rt)));
  assign w_stall = w_rs_stall || w_rt_stall;

  assign fwd_rs_d = fwd_pick(fwd_hit(w_e_we, w_e_wa, w_e_tnew, d_ra1),
                             fwd_hit(w_m_we, w_m_wa, w_m_tnew, d_ra1),
                             fwd_hit(w_w_we, w_w_wa, '0, d_ra1));
  assign fwd_rt_d = fwd_pick(fwd_hit(w_e_we, w_e_wa, w_e_tnew, d_ra2),
                             fwd_hit(w_m_we, w_m_wa, w_m_tnew, d_ra2),
                             fwd_hit(w_w_we, w_w_wa, '0, d_ra2));
  assign fwd_rs_e = fwd_pick(1'b0,
                             fwd_hit(w_m_we, w_m_wa, w_m_tnew, w_e_ra1),
                             fwd_hit(w_w_we, w_w_wa, '0, w_e_ra1));
  assign fwd_rt_e = fwd_pick(1'b0,
                             fwd_hit(w_m_we, w_m_wa, w_m_tnew, w_e_ra2),
                             fwd_hit(w_w_we, w_w_wa, '0, w_e_ra2));
  assign fwd_rt_m = fwd_pick(1'b0, 1'b0, fwd_hit(w_w_we, w_w_wa, '0, w_m_ra2));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule
